mmio_button_bridge: RTL
=======================

# mmio_button_bridge

Memory-mapped I/O bridge between the processor's data-memory port and the board peripherals. It sits on the processor's `q_dmem` return path and write path, alongside the RAM. It turns debounced button levels into sticky, clear-on-read press events with saturating counts. It also registers processor writes to the output address into a valid/ack handshake consumed by `VGAController`.

## Interface
- `ADDR_BTNC`, default 1000: word address of the centre-button event register.
- `ADDR_OUT`, default 2000: write-only output data register to VGA.
- `ADDR_STAT`, default 2004: status register, read only.
- `ADDR_BTNL`, default 3000: left-button event register.
- `ADDR_BTNR`, default 4000: right-button event register.
- `ADDR_BTNU`, default 5000: up-button event register.
- `ADDR_BTND`, default 6000: down-button event register.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `btn_c`, `btn_l`, `btn_r`, `btn_u`, `btn_d` in 1 each: debounced button levels, synchronous to `clock`.
- `address_dmem` in 32: processor data address.
- `wren` in 1: processor write enable.
- `data` in 32: processor write data.
- `mem_q` in 32: RAM read data.
- `q_dmem` out 32: registered read data returned to the processor.
- `to_vga` out 32: latched output word.
- `to_vga_valid` out 1: `to_vga` holds an unconsumed word.
- `vga_ack` in 1: VGA consumed `to_vga`.

## Operation
- Each button has:
  - `prev`, a 1-bit copy of the last level;
  - `evt`, a sticky 1-bit flag;
  - `cnt`, an 8-bit count of rising edges.
- Rising edge (`level & ~prev`):
  - sets `evt`;
  - increments `cnt`, which saturates at 255 and does not wrap.
- Button read (`wren`=0 and address equals that button's address):
  - `q_dmem` <= {16'b0, cnt, 7'b0, evt}, using the pre-clear values.
  - `evt` and `cnt` are cleared on the same edge.
  - If a rising edge occurs on the same edge as a clear, the new event wins: `evt`=1, `cnt`=1.
- Status read (`ADDR_STAT`, `wren`=0):
  - `q_dmem` <= {30'b0, overrun, to_vga_valid}.
  - `overrun` clears on that edge.
- Output write (`wren`=1 and address equals `ADDR_OUT`):
  - `to_vga` <= `data`; `to_vga_valid` <= 1.
  - If `to_vga_valid` was already 1 and `vga_ack`=0 on that edge, `overrun` <= 1.
- `vga_ack`=1 while valid clears `to_vga_valid`.
- Write and ack on the same edge:
  - the new word is latched and `to_vga_valid` stays 1;
  - no overrun, because the ack consumed the old word.
- `vga_ack` while not valid is ignored.
- Any other read: `q_dmem` <= `mem_q`.
- Writes to button or status addresses have no effect on bridge state.
- Address compare uses all 32 bits.

## Timing
- Read latency is one cycle. Address sampled at edge N produces `q_dmem` valid after edge N. Clear-on-read side effects also commit at edge N.
- A read held on the same address for k cycles clears on every one of those cycles. The first returns the event; the following ones return 0 unless a new edge arrives.
- Edge detect has one cycle of latency: a level rising before edge N sets `evt` at edge N.
- On an edge with `reset`=0:
  - `q_dmem`=0, `to_vga`=0, `to_vga_valid`=0, `overrun`=0;
  - all `evt` and `cnt` are 0;
  - each `prev` is loaded with its current button level, so a button held through reset produces no event.
- Reset asserted mid-handshake drops the pending word with no ack required.

## Configuration
- `MMIO_BTN_STICKY_EN` defined: sticky events, counts and clear-on-read, as described above.
- `MMIO_BTN_STICKY_EN` undefined:
  - a button read returns {31'b0, live level} sampled at edge N;
  - no `evt`/`cnt` state is synthesized and there is no clear-on-read.
  - The status register and output path are unchanged.

## Test plan
- Reset while `btn_l`=1, release reset, read 3000 → `q_dmem`=0. Then drop and raise `btn_l`, read 3000 → 0x00000101; read again → 0.
- 300 rising edges on `btn_c`, then read 1000 → 0x0000FF01 (saturated). A rising edge on the same edge as that read → next read returns 0x00000101.
- Write 0x12345678 to 2000 → `to_vga`=0x12345678, valid=1. `vga_ack` → valid=0. Read 2004 → 0x0.
- Write 5 then 7 to 2000 with no ack → `to_vga`=7. Read 2004 → 0x3; read 2004 again → 0x1.
- Write 9 to 2000 on the same edge as `vga_ack` with valid=1 → `to_vga`=9, valid=1, `overrun`=0.
- Read address 12 with `mem_q`=0xDEADBEEF → `q_dmem`=0xDEADBEEF one cycle later. Write to 4000 → `btn_r` event state unchanged.

Source files
------------

// File: rtl/mmio_button_bridge.sv
// ---------------------------------------------------------------------------
// mmio_button_bridge
//
// Memory-mapped bridge between the processor data-memory port and the board
// peripherals. It sits on the q_dmem return path beside the RAM.
//   - Buttons: rising edges become sticky, clear-on-read event flags with
//     8-bit saturating press counts (when MMIO_BTN_STICKY_EN is defined).
//     Without the macro, a button read returns the live level.
//   - Output: processor writes to ADDR_OUT are latched into to_vga with a
//     valid/ack handshake. A status register reports {overrun, valid}.
//
// Build option: `define MMIO_BTN_STICKY_EN to enable sticky events/counts.
//
// Ports:
//   clock          in  1   single clock, rising-edge state updates
//   reset          in  1   synchronous, active-low reset
//   btn_c/l/r/u/d  in  1   debounced button levels, synchronous to clock
//   address_dmem   in  32  processor data address (full 32-bit decode)
//   wren           in  1   processor write enable
//   data           in  32  processor write data
//   mem_q          in  32  RAM read data (returned for unmapped reads)
//   q_dmem         out 32  registered read data, one cycle latency
//   to_vga         out 32  latched output word
//   to_vga_valid   out 1   to_vga holds an unconsumed word
//   vga_ack        in  1   VGA consumed to_vga
// ---------------------------------------------------------------------------
module mmio_button_bridge #(
    parameter logic [31:0] ADDR_BTNC = 32'd1000,
    parameter logic [31:0] ADDR_OUT  = 32'd2000,
    parameter logic [31:0] ADDR_STAT = 32'd2004,
    parameter logic [31:0] ADDR_BTNL = 32'd3000,
    parameter logic [31:0] ADDR_BTNR = 32'd4000,
    parameter logic [31:0] ADDR_BTNU = 32'd5000,
    parameter logic [31:0] ADDR_BTND = 32'd6000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_c,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic [31:0] data,
    input  logic [31:0] mem_q,
    output logic [31:0] q_dmem,
    output logic [31:0] to_vga,
    output logic        to_vga_valid,
    input  logic        vga_ack
);

    logic [31:0] r_q_dmem;
    logic [31:0] r_to_vga;
    logic        r_valid;
    logic        r_overrun;

    logic [4:0]  w_btn;
    logic [4:0]  w_btn_sel;
    logic        w_stat_rd;
    logic        w_out_wr;
    logic [31:0] w_q_next;

    // Bit order: 0=c, 1=l, 2=r, 3=u, 4=d
    assign w_btn = {btn_d, btn_u, btn_r, btn_l, btn_c};

    assign w_btn_sel[0] = !wren && (address_dmem == ADDR_BTNC);
    assign w_btn_sel[1] = !wren && (address_dmem == ADDR_BTNL);
    assign w_btn_sel[2] = !wren && (address_dmem == ADDR_BTNR);
    assign w_btn_sel[3] = !wren && (address_dmem == ADDR_BTNU);
    assign w_btn_sel[4] = !wren && (address_dmem == ADDR_BTND);
    assign w_stat_rd    = !wren && (address_dmem == ADDR_STAT);
    assign w_out_wr     =  wren && (address_dmem == ADDR_OUT);

`ifdef MMIO_BTN_STICKY_EN
    logic [4:0] r_prev;
    logic [4:0] r_evt;
    logic [7:0] r_cnt [5];
    logic [4:0] w_rise;

    assign w_rise = w_btn & ~r_prev;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A rising edge coinciding with a clear-on-read wins: the read returns
    // the old state and the register restarts at evt=1, cnt=1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // Loading the live level means a button held through reset
            // does not produce an event when reset is released.
            r_prev <= w_btn;
            r_evt  <= '0;
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
        end else begin
            r_prev <= w_btn;
            for (int i = 0; i < 5; i++) begin
                if (w_rise[i])
                    r_evt[i] <= 1'b1;
                else if (w_btn_sel[i])
                    r_evt[i] <= 1'b0;

                if (w_btn_sel[i])
                    r_cnt[i] <= w_rise[i] ? 8'd1 : 8'd0;
                else if (w_rise[i])
                    r_cnt[i] <= sat_inc(r_cnt[i]);
            end
        end
    end
`endif

    always_comb begin
        w_q_next = mem_q;
        if (w_stat_rd)
            w_q_next = {30'b0, r_overrun, r_valid};
        for (int i = 0; i < 5; i++) begin
            if (w_btn_sel[i]) begin
`ifdef MMIO_BTN_STICKY_EN
                w_q_next = {16'b0, r_cnt[i], 7'b0, r_evt[i]};
`else
                w_q_next = {31'b0, w_btn[i]};
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_q_dmem  <= '0;
            r_to_vga  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_q_dmem <= w_q_next;

            if (w_out_wr) begin
                r_to_vga <= data;
                r_valid  <= 1'b1;
            end else if (vga_ack) begin
                // Ack with nothing pending simply leaves valid low.
                r_valid <= 1'b0;
            end

            // An ack on the same edge as a write consumed the old word,
            // so only an unacknowledged pending word counts as overrun.
            if (w_out_wr && r_valid && !vga_ack)
                r_overrun <= 1'b1;
            else if (w_stat_rd)
                r_overrun <= 1'b0;
        end
    end

    assign q_dmem       = r_q_dmem;
    assign to_vga       = r_to_vga;
    assign to_vga_valid = r_valid;

endmodule
